// File: rtl/convolutor_pipe_pkg.sv
// convolutor_pipe_pkg: shared defaults, beat mode encoding and the rescale helper.
// Contents: BIT_LEN/M_LEN/CONV_LEN/OUT_LEN defaults, mode_e, sat_round().
// sat_round works on a 64-bit signed value so rounding never wraps before the clamp.
package convolutor_pipe_pkg;

  localparam int BIT_LEN_DEF  = 8;
  localparam int M_LEN_DEF    = 3;
  localparam int CONV_LEN_DEF = 20;
  localparam int OUT_LEN_DEF  = 13;
  localparam int SR_W         = 64;

  // i_selecK_I encoding
  typedef enum logic {
    MODE_KERNEL = 1'b0,
    MODE_IMAGE  = 1'b1
  } mode_e;

  // Round half-up, arithmetic shift right by shift_i, clamp to signed out_len_i bits.
  function automatic logic signed [SR_W-1:0] sat_round(
    input logic signed [SR_W-1:0] sum_i,
    input int                     shift_i,
    input int                     out_len_i
  );
    logic signed [SR_W-1:0] t;
    logic signed [SR_W-1:0] hi;
    logic signed [SR_W-1:0] lo;
    t = sum_i;
    if (shift_i > 0) begin
      t = t + (64'sd1 <<< (shift_i - 1));
    end
    t  = t >>> shift_i;
    hi = (64'sd1 <<< (out_len_i - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_len_i - 1));
    if (t > hi) begin
      t = hi;
    end else if (t < lo) begin
      t = lo;
    end
    return t;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: registered signed sum of N packed IN_W-bit operands, sign-extended to OUT_W.
// Ports: clk_i/rst_i (sync, active-high), vld_i/dat_i operands in, vld_o/sum_o one cycle later.
// Free-running: no backpressure, the valid bit simply travels with the sum.
module conv_adder_tree #(
  parameter int N     = 9,
  parameter int IN_W  = 16,
  parameter int OUT_W = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    vld_i,
  input  logic [N*IN_W-1:0]       dat_i,
  output logic                    vld_o,
  output logic signed [OUT_W-1:0] sum_o
);

  if (OUT_W <= IN_W) begin : g_width_chk
    $error("conv_adder_tree: OUT_W must exceed IN_W");
  end

  logic signed [OUT_W-1:0] sum_d;
  logic signed [OUT_W-1:0] sum_q;
  logic                    vld_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + $signed({{(OUT_W-IN_W){dat_i[i*IN_W+IN_W-1]}}, dat_i[i*IN_W +: IN_W]});
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      sum_q <= '0;
    end else begin
      vld_q <= vld_i;
      sum_q <= sum_d;
    end
  end

  assign vld_o = vld_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/convolutor_pipe.sv
// convolutor_pipe: pipelined MxM signed convolution, one image column per beat, 3-cycle latency.
// Ports: i_CLK, i_reset (sync, active-high), i_col/i_selecK_I/i_valid/i_row_start beat inputs;
//        o_kernel_rdy (kernel fully loaded), o_data/o_valid result (o_data holds between pulses).
module convolutor_pipe
  import convolutor_pipe_pkg::*;
#(
  parameter int BIT_LEN    = BIT_LEN_DEF,
  parameter int M_LEN      = M_LEN_DEF,
  parameter int CONV_LEN   = CONV_LEN_DEF,
  parameter int OUT_LEN    = OUT_LEN_DEF,
  parameter bit OFFSET_OUT = 1'b1
) (
  input  logic                     i_CLK,
  input  logic                     i_reset,
  input  logic [M_LEN*BIT_LEN-1:0] i_col,
  input  logic                     i_selecK_I,
  input  logic                     i_valid,
  input  logic                     i_row_start,
  output logic                     o_kernel_rdy,
  output logic [OUT_LEN-1:0]       o_data,
  output logic                     o_valid
);

  localparam int SHIFT = CONV_LEN - OUT_LEN;
  localparam int NPROD = M_LEN * M_LEN;
  localparam int PW    = 2 * BIT_LEN;
  localparam int CW    = $clog2(M_LEN + 1);
  localparam int COLW  = M_LEN * BIT_LEN;

  if (CONV_LEN < 2*BIT_LEN + $clog2(M_LEN*M_LEN)) begin : g_conv_len_chk
    $error("convolutor_pipe: CONV_LEN too narrow for the product sum");
  end
  if (OUT_LEN > CONV_LEN) begin : g_out_len_chk
    $error("convolutor_pipe: OUT_LEN must not exceed CONV_LEN");
  end

  logic [COLW-1:0] kwin_q [M_LEN];
  logic [COLW-1:0] kwin_d [M_LEN];
  logic [COLW-1:0] iwin_q [M_LEN];
  logic [COLW-1:0] iwin_d [M_LEN];
  logic [CW-1:0]   kcnt_q, kcnt_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic            krdy_q;
  logic            kern_beat, img_beat;

  assign kern_beat = i_valid && (mode_e'(i_selecK_I) == MODE_KERNEL);
  assign img_beat  = i_valid && (mode_e'(i_selecK_I) == MODE_IMAGE);

  // Both windows shift oldest-out at index 0; the newest column always lands at M_LEN-1.
  always_comb begin
    kwin_d = kwin_q;
    iwin_d = iwin_q;
    kcnt_d = kcnt_q;
    fill_d = fill_q;
    if (kern_beat) begin
      for (int c = 0; c < M_LEN-1; c++) kwin_d[c] = kwin_q[c+1];
      kwin_d[M_LEN-1] = i_col;
      if (kcnt_q != CW'(M_LEN)) kcnt_d = kcnt_q + 1'b1;
    end
    if (img_beat) begin
      for (int c = 0; c < M_LEN-1; c++) iwin_d[c] = iwin_q[c+1];
      iwin_d[M_LEN-1] = i_col;
      if (i_row_start)                 fill_d = CW'(1);
      else if (fill_q != CW'(M_LEN))   fill_d = fill_q + 1'b1;
    end
  end

  // S1 uses the window including this beat's column so latency stays at 3.
  logic                  s1_vld_d, s1_vld_q;
  logic [NPROD*PW-1:0]   prod_d, prod_q;
  logic signed [PW-1:0]  ka, ia;

  assign s1_vld_d = img_beat && (fill_d == CW'(M_LEN)) && krdy_q;

  always_comb begin
    prod_d = '0;
    ka     = '0;
    ia     = '0;
    for (int c = 0; c < M_LEN; c++) begin
      for (int r = 0; r < M_LEN; r++) begin
        ka = {{BIT_LEN{kwin_q[c][r*BIT_LEN+BIT_LEN-1]}}, kwin_q[c][r*BIT_LEN +: BIT_LEN]};
        ia = {{BIT_LEN{iwin_d[c][r*BIT_LEN+BIT_LEN-1]}}, iwin_d[c][r*BIT_LEN +: BIT_LEN]};
        prod_d[(c*M_LEN+r)*PW +: PW] = ka * ia;
      end
    end
  end

  logic                       s2_vld;
  logic signed [CONV_LEN-1:0] s2_sum;

  conv_adder_tree #(
    .N     (NPROD),
    .IN_W  (PW),
    .OUT_W (CONV_LEN)
  ) u_tree (
    .clk_i (i_CLK),
    .rst_i (i_reset),
    .vld_i (s1_vld_q),
    .dat_i (prod_q),
    .vld_o (s2_vld),
    .sum_o (s2_sum)
  );

  // S3: rescale and clamp; only the low OUT_LEN bits of the clamped value carry information.
  logic signed [SR_W-1:0] sum_ext, sr;
  logic                   unused_sr_hi;
  logic [OUT_LEN-1:0]     data_d, data_q;
  logic                   valid_q;

  assign sum_ext      = {{(SR_W-CONV_LEN){s2_sum[CONV_LEN-1]}}, s2_sum};
  assign sr           = sat_round(sum_ext, SHIFT, OUT_LEN);
  assign unused_sr_hi = ^sr[SR_W-1:OUT_LEN];

  always_comb begin
    data_d = sr[OUT_LEN-1:0];
    if (OFFSET_OUT) data_d[OUT_LEN-1] = ~data_d[OUT_LEN-1];
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      kwin_q   <= '{default: '0};
      iwin_q   <= '{default: '0};
      kcnt_q   <= '0;
      fill_q   <= '0;
      krdy_q   <= 1'b0;
      s1_vld_q <= 1'b0;
      prod_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      kwin_q   <= kwin_d;
      iwin_q   <= iwin_d;
      kcnt_q   <= kcnt_d;
      fill_q   <= fill_d;
      krdy_q   <= (kcnt_d == CW'(M_LEN));
      s1_vld_q <= s1_vld_d;
      prod_q   <= prod_d;
      valid_q  <= s2_vld;
      if (s2_vld) data_q <= data_d;
    end
  end

  assign o_kernel_rdy = krdy_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;

endmodule
